// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: state codes, opcodes, ALU codes and IR field helpers shared by the control FSM.
package proc_ctrl_pkg;
   localparam logic [2:0] S_T0 = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
                          S_T4 = 3'd4, S_T5 = 3'd5, S_HALT = 3'd6;
   localparam int OP_MV = 0, OP_MVI = 1, OP_ADD = 2, OP_SUB = 3, OP_LD = 4, OP_ST = 5,
                  OP_MVNZ = 6, OP_ADDF = 7, OP_AND = 8, OP_B = 9, OP_BZ = 10, OP_HALT = 11;
   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10;

   function automatic logic [31:0] ir_field(input logic [31:0] ir, input int lsb, input int w);
      return (ir >> lsb) & ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] ir_opc(input logic [31:0] ir, input int ra_w, input int opc_w);
      return ir_field(ir, 2 * ra_w, opc_w);
   endfunction

   function automatic logic [31:0] ir_rx(input logic [31:0] ir, input int ra_w);
      return ir_field(ir, ra_w, ra_w);
   endfunction

   function automatic logic [31:0] ir_ry(input logic [31:0] ir, input int ra_w);
      return ir_field(ir, 0, ra_w);
   endfunction
endpackage

// File: rtl/proc_ctrl_if.sv
// proc_ctrl_if: instruction/flag inputs and datapath strobes between control FSM and datapath.
interface proc_ctrl_if #(parameter int RA_W = 3, parameter int OPC_W = 4);
   localparam int NREGS = 2 ** RA_W;
   localparam int IR_W = OPC_W + 2 * RA_W;
   logic run, resume, gzero, mem_ready;
   logic [IR_W-1:0] IR;
   logic [NREGS-1:0] Rout, Rin;
   logic DINout, Gout, GFout;
   logic IRin, Ain, AFin, Gin, GFin;
   logic [1:0] alu_op;
   logic incr_pc, ADDRin, DOUTin, W_D, mem_rd;
   logic done, illegal_op, bus_err, halted;
   modport master (
      input  run, resume, IR, gzero, mem_ready,
      output Rout, Rin, DINout, Gout, GFout, IRin, Ain, AFin, Gin, GFin, alu_op,
             incr_pc, ADDRin, DOUTin, W_D, mem_rd, done, illegal_op, bus_err, halted
   );
   modport slave (
      output run, resume, IR, gzero, mem_ready,
      input  Rout, Rin, DINout, Gout, GFout, IRin, Ain, AFin, Gin, GFin, alu_op,
             incr_pc, ADDRin, DOUTin, W_D, mem_rd, done, illegal_op, bus_err, halted
   );
endinterface

// File: rtl/proc_ctrl_gen_dec.sv
// proc_dec_onehot: register address to one-hot select.
module proc_dec_onehot #(parameter int W = 3) (
   input  logic [W-1:0]    sel,
   output logic [2**W-1:0] oh
);
   localparam int N = 2 ** W;
   assign oh = N'(1) << sel;
endmodule

// File: rtl/proc_ctrl_gen.sv
// proc_ctrl_gen: multi-cycle processor control FSM with memory ready handshake and wait timeout.
module proc_ctrl_gen import proc_ctrl_pkg::*; #(
   parameter int RA_W = 3,
   parameter int OPC_W = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input logic         clk,
   input logic         rstn,
   proc_ctrl_if.master bus
);
   localparam int NREGS = 2 ** RA_W;
   localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
   logic [2:0] state, nxt;
   logic [CW-1:0] cnt;
   logic [RA_W-1:0] rx, ry;
   logic [NREGS-1:0] rx_oh, ry_oh, pc_oh;
   int opc;
   logic wait_st, tmo;
   assign opc = ir_opc(32'(bus.IR), RA_W, OPC_W);
   assign rx = RA_W'(ir_rx(32'(bus.IR), RA_W));
   assign ry = RA_W'(ir_ry(32'(bus.IR), RA_W));
   proc_dec_onehot #(.W(RA_W)) u_rx (.sel(rx), .oh(rx_oh));
   proc_dec_onehot #(.W(RA_W)) u_ry (.sel(ry), .oh(ry_oh));
   proc_dec_onehot #(.W(RA_W)) u_pc (.sel({RA_W{1'b1}}), .oh(pc_oh));
   assign wait_st = state == S_T1 || (state == S_T4 && (opc == OP_MVI || opc == OP_LD || opc == OP_ST));
   // a ready arriving in the timeout cycle still completes the access
   assign tmo = MEM_TIMEOUT != 0 && wait_st && !bus.mem_ready && cnt == CW'(MEM_TIMEOUT);
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_T0;
         cnt <= '0;
      end else begin
         state <= nxt;
         cnt <= (MEM_TIMEOUT != 0 && wait_st && !bus.mem_ready && !tmo) ? cnt + 1'b1 : '0;
      end
   end
   always_comb begin
      nxt = S_T0;
      bus.Rout = '0;
      bus.Rin = '0;
      {bus.DINout, bus.Gout, bus.GFout, bus.IRin, bus.Ain, bus.AFin, bus.Gin, bus.GFin} = '0;
      bus.alu_op = ALU_ADD;
      {bus.incr_pc, bus.ADDRin, bus.DOUTin, bus.W_D, bus.mem_rd} = '0;
      {bus.done, bus.illegal_op, bus.bus_err, bus.halted} = '0;
      case (state)
         S_T0: if (bus.run) begin
            bus.Rout = pc_oh;
            bus.ADDRin = 1'b1;
            bus.incr_pc = 1'b1;
            nxt = S_T1;
         end
         S_T1: begin
            bus.mem_rd = !tmo;
            bus.bus_err = tmo;
            bus.done = tmo;
            nxt = bus.mem_ready ? S_T2 : tmo ? S_T0 : S_T1;
         end
         S_T2: begin
            bus.IRin = 1'b1;
            nxt = S_T3;
         end
         S_T3: case (opc)
            OP_MV: {bus.Rout, bus.Rin, bus.done} = {ry_oh, rx_oh, 1'b1};
            OP_MVI: {bus.Rout, bus.ADDRin, bus.incr_pc, nxt} = {pc_oh, 1'b1, 1'b1, S_T4};
            OP_ADD, OP_SUB, OP_AND, OP_ADDF: begin
               bus.Rout = rx_oh;
               bus.Ain = opc != OP_ADDF;
               bus.AFin = opc == OP_ADDF;
               nxt = S_T4;
            end
            OP_LD, OP_ST: {bus.Rout, bus.ADDRin, nxt} = {ry_oh, 1'b1, S_T4};
            OP_MVNZ: {bus.Rout, bus.Rin, bus.done} = {bus.gzero ? '0 : ry_oh, bus.gzero ? '0 : rx_oh, 1'b1};
            OP_B: {bus.Rout, bus.Rin, bus.done} = {ry_oh, pc_oh, 1'b1};
            OP_BZ: {bus.Rout, bus.Rin, bus.done} = {bus.gzero ? ry_oh : '0, bus.gzero ? pc_oh : '0, 1'b1};
            OP_HALT: {bus.done, nxt} = {1'b1, S_HALT};
            default: {bus.illegal_op, bus.done} = 2'b11;
         endcase
         S_T4: case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_ADDF: begin
               bus.Rout = ry_oh;
               bus.Gin = opc != OP_ADDF;
               bus.GFin = opc == OP_ADDF;
               bus.alu_op = opc == OP_SUB ? ALU_SUB : opc == OP_AND ? ALU_AND : ALU_ADD;
               nxt = S_T5;
            end
            OP_MVI, OP_LD, OP_ST: begin
               bus.mem_rd = !tmo && opc != OP_ST;
               bus.Rout = (!tmo && opc == OP_ST) ? rx_oh : '0;
               bus.DOUTin = !tmo && opc == OP_ST;
               bus.W_D = !tmo && opc == OP_ST;
               bus.bus_err = tmo;
               bus.done = tmo;
               nxt = bus.mem_ready ? S_T5 : tmo ? S_T0 : S_T4;
            end
            default: nxt = S_T0;
         endcase
         S_T5: begin
            bus.Gout = opc == OP_ADD || opc == OP_SUB || opc == OP_AND;
            bus.GFout = opc == OP_ADDF;
            bus.DINout = opc == OP_MVI || opc == OP_LD;
            bus.Rin = (bus.Gout || bus.GFout || bus.DINout) ? rx_oh : '0;
            bus.done = 1'b1;
         end
         S_HALT: begin
            bus.halted = 1'b1;
            nxt = bus.resume ? S_T0 : S_HALT;
         end
         default: nxt = S_T0;
      endcase
   end
endmodule

// File: tb/tb_proc_ctrl_gen.sv
// tb_proc_ctrl_gen: random and directed instruction streams checked cycle by cycle against an instruction-level model.
module tb_proc_ctrl_gen;
   localparam int RA_W = 3, OPC_W = 4, TO = 15;
   localparam logic [7:0] PC = 8'h80;
   localparam logic [16:0] DINOUT = 17'h1, GOUT = 17'h2, GFOUT = 17'h4, IRIN = 17'h8,
                           AIN = 17'h10, AFIN = 17'h20, GIN = 17'h40, GFIN = 17'h80,
                           INCR = 17'h100, ADDRIN = 17'h200, DOUTIN = 17'h400, WD = 17'h800,
                           MEMRD = 17'h1000, DONE = 17'h2000, ILL = 17'h4000, BERR = 17'h8000,
                           HALTED = 17'h10000;
   typedef struct packed {
      logic run;
      logic resume;
      logic rdy;
      logic [34:0] o;
   } cyc_t;
   logic clk = 1'b0;
   logic rstn = 1'b1;
   int checks = 0, failures = 0;
   cyc_t q[$];
   logic [34:0] obs;
   proc_ctrl_if #(.RA_W(RA_W), .OPC_W(OPC_W)) bus ();
   proc_ctrl_gen #(.RA_W(RA_W), .OPC_W(OPC_W), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;
   assign obs = {bus.Rout, bus.Rin, bus.alu_op, bus.halted, bus.bus_err, bus.illegal_op, bus.done,
                 bus.mem_rd, bus.W_D, bus.DOUTin, bus.ADDRin, bus.incr_pc, bus.GFin, bus.Gin,
                 bus.AFin, bus.Ain, bus.IRin, bus.GFout, bus.Gout, bus.DINout};

   task automatic check(string tag, logic [34:0] got, logic [34:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void push(logic run, logic resume, logic rdy, logic [7:0] rout, logic [7:0] rin,
                                logic [1:0] alu, logic [16:0] f);
      q.push_back({run, resume, rdy, rout, rin, alu, f});
   endfunction

   // memory wait of d cycles; returns 1 when the access is abandoned
   function automatic logic wait_phase(logic [7:0] rout, logic [16:0] f, int d);
      for (int i = 0; i <= TO; i++) begin
         if (i == d) begin
            push(1'b0, 1'b0, 1'b1, rout, '0, '0, f);
            return 1'b0;
         end
         if (i == TO) begin
            push(1'b0, 1'b0, 1'b0, '0, '0, '0, BERR | DONE);
            return 1'b1;
         end
         push(1'b0, 1'b0, 1'b0, rout, '0, '0, f);
      end
      return 1'b1;
   endfunction

   function automatic void build(int op, int rx, int ry, logic gz, int d1, int d2, int hn);
      logic [7:0] x, y;
      x = 8'd1 << rx;
      y = 8'd1 << ry;
      push(1'b1, 1'b0, 1'b0, PC, '0, '0, INCR | ADDRIN);
      if (wait_phase('0, MEMRD, d1)) return;
      push(1'b0, 1'b0, 1'b0, '0, '0, '0, IRIN);
      case (op)
         0: push(1'b0, 1'b0, 1'b0, y, x, '0, DONE);
         1: begin
            push(1'b0, 1'b0, 1'b0, PC, '0, '0, ADDRIN | INCR);
            if (!wait_phase('0, MEMRD, d2)) push(1'b0, 1'b0, 1'b0, '0, x, '0, DINOUT | DONE);
         end
         2, 3, 8: begin
            push(1'b0, 1'b0, 1'b0, x, '0, '0, AIN);
            push(1'b0, 1'b0, 1'b0, y, '0, op == 3 ? 2'b01 : op == 8 ? 2'b10 : 2'b00, GIN);
            push(1'b0, 1'b0, 1'b0, '0, x, '0, GOUT | DONE);
         end
         4: begin
            push(1'b0, 1'b0, 1'b0, y, '0, '0, ADDRIN);
            if (!wait_phase('0, MEMRD, d2)) push(1'b0, 1'b0, 1'b0, '0, x, '0, DINOUT | DONE);
         end
         5: begin
            push(1'b0, 1'b0, 1'b0, y, '0, '0, ADDRIN);
            if (!wait_phase(x, DOUTIN | WD, d2)) push(1'b0, 1'b0, 1'b0, '0, '0, '0, DONE);
         end
         6: push(1'b0, 1'b0, 1'b0, gz ? '0 : y, gz ? '0 : x, '0, DONE);
         7: begin
            push(1'b0, 1'b0, 1'b0, x, '0, '0, AFIN);
            push(1'b0, 1'b0, 1'b0, y, '0, '0, GFIN);
            push(1'b0, 1'b0, 1'b0, '0, x, '0, GFOUT | DONE);
         end
         9: push(1'b0, 1'b0, 1'b0, y, PC, '0, DONE);
         10: push(1'b0, 1'b0, 1'b0, gz ? y : '0, gz ? PC : '0, '0, DONE);
         11: begin
            push(1'b0, 1'b0, 1'b0, '0, '0, '0, DONE);
            for (int i = 0; i < hn; i++) push(1'b1, 1'b0, 1'b0, '0, '0, '0, HALTED);
            push(1'b0, 1'b1, 1'b0, '0, '0, '0, HALTED);
         end
         default: push(1'b0, 1'b0, 1'b0, '0, '0, '0, ILL | DONE);
      endcase
   endfunction

   task automatic apply(int n, string name);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c = q.pop_front();
         bus.run = c.run;
         bus.resume = c.resume;
         bus.mem_ready = c.rdy;
         #3 check($sformatf("%s c%0d", name, i), obs, c.o);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic instr(string name, int op, int rx, int ry, logic gz, int d1, int d2, int hn);
      bus.IR = {4'(op), 3'(rx), 3'(ry)};
      bus.gzero = gz;
      q.delete();
      build(op, rx, ry, gz, d1, d2, hn);
      push(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      apply(q.size(), name);
   endtask

   function automatic int rd();
      int r;
      r = int'($urandom_range(9, 0));
      return r < 7 ? int'($urandom_range(3, 0)) : r == 7 ? TO : r == 8 ? TO - 1 : TO + 5;
   endfunction

   initial begin
      bus.run = 1'b0;
      bus.resume = 1'b0;
      bus.IR = '0;
      bus.gzero = 1'b0;
      bus.mem_ready = 1'b0;
      #1 rstn = 1'b0;
      #1 check("reset", obs, '0);
      @(posedge clk);
      #1 rstn = 1'b1;
      instr("mvi_late", 1, 0, 5, 1'b0, 2, 2, 0);
      instr("sub", 3, 2, 3, 1'b0, 0, 0, 0);
      instr("bz_taken", 10, 0, 1, 1'b1, 0, 0, 0);
      instr("bz_not", 10, 0, 1, 1'b0, 0, 0, 0);
      instr("st_timeout", 5, 1, 2, 1'b0, 0, 100, 0);
      instr("illegal13", 13, 4, 6, 1'b0, 1, 0, 0);
      instr("halt", 11, 0, 0, 1'b0, 0, 0, 10);
      instr("fetch_timeout", 0, 3, 4, 1'b0, 40, 0, 0);
      instr("ld_ready_at_limit", 4, 7, 2, 1'b0, TO, TO, 0);
      instr("mv_pc", 0, 7, 1, 1'b0, 0, 0, 0);
      bus.IR = {4'(2), 3'(1), 3'(2)};
      q.delete();
      build(2, 1, 2, 1'b0, 0, 0, 0);
      apply(4, "add_rst");
      bus.run = 1'b0;
      bus.mem_ready = 1'b0;
      #1 rstn = 1'b0;
      #1 check("rst_async", obs, '0);
      @(posedge clk);
      #1 rstn = 1'b1;
      q.delete();
      repeat (3) push(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      apply(3, "post_rst");
      instr("mv_after_rst", 0, 2, 5, 1'b0, 0, 0, 0);
      for (int k = 0; k < 60; k++) begin
         int op;
         op = int'($urandom_range(15, 0));
         instr($sformatf("r%0d_op%0d", k, op), op, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
               1'($urandom_range(1, 0)), rd(), rd(), int'($urandom_range(3, 0)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
